// File: rtl/ps2mouse_kmouse_decoder_if.sv
// Received PS/2 byte stream: one byte per one-cycle strobe, no backpressure.
interface ps2mouse_kmouse_decoder_if;
  logic [7:0] data;
  logic       data_valid;

  modport master (output data, output data_valid);
  modport slave  (input  data, input  data_valid);
endinterface

// File: rtl/ps2mouse_kmouse_decoder.sv
// Frames PS/2 mouse packets and accumulates them into Kempston X/Y/button registers.
// Define PS2MOUSE_WHEEL_EN for 4-byte IntelliMouse packets and the wheel nibble.
module ps2mouse_kmouse_decoder #(
  parameter int unsigned TIMEOUT = 56000
) (
  input  logic                           clk,
  input  logic                           rst,
  // Handshake: the source asserts data_valid for exactly one cycle with data
  // stable in that cycle; the decoder always accepts (no ready), one byte per strobe.
  ps2mouse_kmouse_decoder_if.slave       rx,
`ifdef PS2MOUSE_WHEEL_EN
  input  logic                           intellimouse,
`endif
  output logic [7:0]                     kmouse_x,
  output logic [7:0]                     kmouse_y,
  output logic [7:0]                     kmouse_buttons,
  output logic                           packet_valid,
  output logic                           sync_error,
  output logic [1:0]                     fsm_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    HDR = 2'd0,
    DX  = 2'd1,
    DY  = 2'd2,
    DZ  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Only the header bits that matter after framing: overflow flags and buttons.
  logic            ovf_y_q, ovf_x_q, btn_mid_q, btn_right_q, btn_left_q;
  logic [7:0]      dx_q;
  logic [2:0]      btn_lo_q;
  logic [3:0]      wheel_nib;
  logic [7:0]      dy_byte;
  logic            wheel_pkt;

  logic            hdr_ld, dx_ld, apply, reject;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_ld  = 1'b0;
    dx_ld   = 1'b0;
    apply   = 1'b0;
    reject  = 1'b0;
    if (rx.data_valid) begin
      // A byte always wins over a coincident timeout.
      cnt_d = '0;
      case (state_q)
        HDR: begin
          if (rx.data[3]) begin
            hdr_ld  = 1'b1;
            state_d = DX;
          end else begin
            reject = 1'b1;
          end
        end
        DX: begin
          dx_ld   = 1'b1;
          state_d = DY;
        end
        DY: begin
          if (wheel_pkt) begin
            state_d = DZ;
          end else begin
            apply   = 1'b1;
            state_d = HDR;
          end
        end
        DZ: begin
          apply   = 1'b1;
          state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end else if (state_q != HDR) begin
      if (cnt_q == CW'(TIMEOUT)) begin
        state_d = HDR;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HDR;
      cnt_q        <= '0;
      ovf_y_q      <= 1'b0;
      ovf_x_q      <= 1'b0;
      btn_mid_q    <= 1'b0;
      btn_right_q  <= 1'b0;
      btn_left_q   <= 1'b0;
      dx_q         <= 8'h00;
      kmouse_x     <= 8'h00;
      kmouse_y     <= 8'h00;
      btn_lo_q     <= 3'b111;
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      packet_valid <= apply;
      sync_error   <= reject;
      if (hdr_ld) begin
        ovf_y_q     <= rx.data[7];
        ovf_x_q     <= rx.data[6];
        btn_mid_q   <= rx.data[2];
        btn_right_q <= rx.data[1];
        btn_left_q  <= rx.data[0];
      end
      if (dx_ld) begin
        dx_q <= rx.data;
      end
      // The 9th (sign) bit never affects an 8-bit wrapping sum, so only the low byte is added.
      if (apply) begin
        if (!ovf_x_q) kmouse_x <= kmouse_x + dx_q;
        if (!ovf_y_q) kmouse_y <= kmouse_y + dy_byte;
        btn_lo_q <= {~btn_mid_q, ~btn_left_q, ~btn_right_q};
      end
    end
  end

`ifdef PS2MOUSE_WHEEL_EN
  logic       wheel_pkt_q;
  logic [7:0] dy_q;
  logic [3:0] wheel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wheel_pkt_q <= 1'b0;
      dy_q        <= 8'h00;
      wheel_q     <= 4'h0;
    end else begin
      if (hdr_ld) wheel_pkt_q <= intellimouse;
      if (rx.data_valid && state_q == DY) dy_q <= rx.data;
      if (apply && state_q == DZ) wheel_q <= wheel_q + rx.data[3:0];
    end
  end

  assign wheel_pkt = wheel_pkt_q;
  assign dy_byte   = (state_q == DZ) ? dy_q : rx.data;
  assign wheel_nib = wheel_q;
`else
  assign wheel_pkt = 1'b0;
  assign dy_byte   = rx.data;
  assign wheel_nib = 4'hF;
`endif

  assign kmouse_buttons = {wheel_nib, 1'b1, btn_lo_q};
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_ps2mouse_kmouse_decoder.sv
// Scoreboard bench for ps2mouse_kmouse_decoder: directed packets plus random byte streams.
module tb_ps2mouse_kmouse_decoder;
  localparam int TO = 300;
`ifdef PS2MOUSE_WHEEL_EN
  localparam bit WHEEL = 1'b1;
`else
  localparam bit WHEEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       intellimouse = 1'b0;
  logic [7:0] kx, ky, kb;
  logic       pv, se;
  logic [1:0] fsm_state;

  ps2mouse_kmouse_decoder_if rx_if ();

  ps2mouse_kmouse_decoder #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx_if.slave),
`ifdef PS2MOUSE_WHEEL_EN
    .intellimouse   (intellimouse),
`endif
    .kmouse_x       (kx),
    .kmouse_y       (ky),
    .kmouse_buttons (kb),
    .packet_valid   (pv),
    .sync_error     (se),
    .fsm_state      (fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mx, my, mbtn;
  logic [3:0]  mwheel;
  logic [7:0]  pkt[$];
  bit          pkt_wheel;
  int          idle_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [24:0] exp_q[$];

  function automatic void model_reset();
    mx = 8'h00; my = 8'h00; mwheel = 4'h0;
    mbtn = WHEEL ? 8'h0F : 8'hFF;
    pkt.delete();
    idle_cnt = 0;
  endfunction

  function automatic void model_apply();
    logic [7:0] h;
    h = pkt[0];
    if (!h[6]) mx = mx + pkt[1];
    if (!h[7]) my = my + pkt[2];
    if (pkt.size() == 4) mwheel = mwheel + pkt[3][3:0];
    mbtn = {(WHEEL ? mwheel : 4'hF), 1'b1, ~h[2], ~h[0], ~h[1]};
    exp_q.push_back({1'b0, mx, my, mbtn});
    pkt.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (pkt.size() > 0 && idle_cnt > TO) pkt.delete();
    if (pkt.size() == 0 && !b[3]) begin
      exp_q.push_back({1'b1, mx, my, mbtn});
    end else begin
      if (pkt.size() == 0) pkt_wheel = WHEEL && intellimouse;
      pkt.push_back(b);
      if (pkt.size() == (pkt_wheel ? 4 : 3)) model_apply();
    end
  endfunction

  // Driver tasks: always entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      idle_cnt++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    rx_if.data       = b;
    rx_if.data_valid = 1'b1;
    @(posedge clk); #1;
    rx_if.data_valid = 1'b0;
    idle_cnt = 0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_drained(input string name);
    idle(2);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [24:0] act, e;
    if (!rst && (pv || se)) begin
      act = {se, kx, ky, kb};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse act=%h exp=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e || (pv && se)) begin
          errors++;
          $display("FAIL scoreboard act=%h pv=%0b se=%0b exp=%h", act, pv, se, e);
        end
      end
    end
  end

  initial begin
    rx_if.data       = 8'h00;
    rx_if.data_valid = 1'b0;
    model_reset();
    rst = 1'b1;
    idle(3);
    check("rst_x", kx, 8'h00);
    check("rst_y", ky, 8'h00);
    check("rst_btn", kb, WHEEL ? 8'h0F : 8'hFF);
    check("rst_pv", pv, 0);
    check("rst_se", se, 0);
    rst = 1'b0;
    model_reset();
    idle(1);

    // Basic packet, left button
    send3(8'h09, 8'h05, 8'h03);
    check_drained("basic_drain");
    check("basic_x", kx, 8'h05);
    check("basic_y", ky, 8'h03);
    check("basic_btn", kb, WHEEL ? 8'h0D : 8'hFD);

    // Negative dx, then X overflow
    send3(8'h08, 8'hFD, 8'h00);
    send3(8'h18, 8'hFC, 8'h00);
    check_drained("neg_drain");
    check("neg_x", kx, 8'hFE);
    check("neg_y", ky, 8'h03);
    send3(8'h48, 8'h10, 8'h10);
    check_drained("ovf_drain");
    check("ovf_x", kx, 8'hFE);
    check("ovf_y", ky, 8'h13);

    // Resync on a bad header
    send(8'h00);
    send3(8'h08, 8'h01, 8'h01);
    check_drained("sync_drain");
    check("sync_x", kx, 8'hFF);
    check("sync_y", ky, 8'h14);

    // Timeout drops a partial packet
    send(8'h08); send(8'h20);
    idle(TO + 1);
    send3(8'h08, 8'h01, 8'h02);
    check_drained("to_drain");
    check("to_x", kx, 8'h00);
    check("to_y", ky, 8'h16);

    // A gap of exactly TIMEOUT idle cycles is still within the packet
    send(8'h08); send(8'h01);
    idle(TO);
    send(8'h01);
    check_drained("edge_drain");
    check("edge_x", kx, 8'h01);
    check("edge_y", ky, 8'h17);

`ifdef PS2MOUSE_WHEEL_EN
    intellimouse = 1'b1;
    send3(8'h08, 8'h00, 8'h00); send(8'h0F);
    check_drained("wheel1_drain");
    check("wheel1_btn", kb, 8'hFF);
    send3(8'h08, 8'h00, 8'h00); send(8'h0F);
    check_drained("wheel2_drain");
    check("wheel2_btn", kb, 8'hEF);
    intellimouse = 1'b0;
`endif

    // Reset mid-packet
    send(8'h09); send(8'h05);
    rst = 1'b1;
    #2;
    check("midrst_x", kx, 8'h00);
    check("midrst_y", ky, 8'h00);
    check("midrst_btn", kb, WHEEL ? 8'h0F : 8'hFF);
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(1);
    send3(8'h09, 8'h05, 8'h03);
    check_drained("postrst_drain");
    check("postrst_x", kx, 8'h05);
    check("postrst_y", ky, 8'h03);

    // Random stream: mostly valid headers, random gaps, occasional timeouts
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int g;
      b = 8'($urandom_range(0, 255));
      if (pkt.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
      if (WHEEL) intellimouse = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 39) == 0) ? TO + int'($urandom_range(1, 20))
                                       : int'($urandom_range(0, 3));
      idle(g);
      send(b);
    end
    check_drained("random_drain");
    check("final_x", kx, 32'(mx));
    check("final_y", ky, 32'(my));
    check("final_btn", kb, 32'(mbtn));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
